// File: rtl/core_sequencer_if.sv
// core_sequencer_if
// Shared memory port between the core sequencer (master) and the memory (slave).
//
// Handshake: the master raises mem_req together with mem_we and mem_instr and
// holds all three stable until a cycle in which it samples mem_ready=1; that
// cycle completes the access. mem_ready is ignored whenever mem_req=0. A
// request is only ever withdrawn by reset or by the master's bus timeout.
//
// Signals:
//   mem_req    master->slave  access request
//   mem_we     master->slave  store strobe, only high together with mem_req
//   mem_instr  master->slave  address mux: 1 = pc (fetch), 0 = load/store address
//   mem_ready  slave->master  access acknowledge
interface core_sequencer_if;
  logic mem_req;
  logic mem_we;
  logic mem_instr;
  logic mem_ready;

  modport master (
    output mem_req,
    output mem_we,
    output mem_instr,
    input  mem_ready
  );

  modport slave (
    input  mem_req,
    input  mem_we,
    input  mem_instr,
    output mem_ready
  );
endinterface

// File: rtl/core_sequencer.sv
// core_sequencer
// Multi-cycle control FSM for the RV32I core. Steps every instruction through
// FETCH -> DECODE -> EXEC -> (MEM) -> (WB) over one shared memory port and
// drives the enables/selects of the pc register, instruction register,
// register file and data memory.
//
// Parameters:
//   MEM_TIMEOUT  wait cycles tolerated on mem_ready before a bus fault (1..255)
//   CNT_W        width of the retired-instruction counter
//
// Ports:
//   clock, reset_n   clock (rising edge), asynchronous active-low reset
//   mem              memory port (master side): mem_req/mem_we/mem_instr/mem_ready
//   opcode, funct3   fields of the latched instruction, valid from DECODE onward
//   branch_taken     ALU branch compare result, valid in EXEC
//   ir_en            instruction register load pulse
//   pc_en, pc_sel    pc update pulse; 00 pc+4, 01 pc+imm, 10 (rs1+imm)&~1
//   reg_w_en, wb_sel register write pulse; 00 ALU, 01 memory, 10 pc+4
//   halt, fault      sticky stop flag; 00 none/ECALL-EBREAK, 01 illegal, 10 bus timeout
//   state            current FSM state, for debug
//   instret          retired-instruction count (wraps)
module core_sequencer #(
  parameter int unsigned MEM_TIMEOUT = 15,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             clock,
  input  logic             reset_n,
  core_sequencer_if.master mem,
  input  logic [6:0]       opcode,
  input  logic [2:0]       funct3,
  input  logic             branch_taken,
  output logic             ir_en,
  output logic             pc_en,
  output logic [1:0]       pc_sel,
  output logic             reg_w_en,
  output logic [1:0]       wb_sel,
  output logic             halt,
  output logic [1:0]       fault,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] instret
);

  // FSM states
  localparam logic [2:0] S_FETCH  = 3'd0;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_EXEC   = 3'd2;
  localparam logic [2:0] S_MEM    = 3'd3;
  localparam logic [2:0] S_WB     = 3'd4;
  localparam logic [2:0] S_HALT   = 3'd5;

  // Instruction classes held in the class register
  localparam logic [2:0] C_ALU    = 3'd0;
  localparam logic [2:0] C_LOAD   = 3'd1;
  localparam logic [2:0] C_STORE  = 3'd2;
  localparam logic [2:0] C_BRANCH = 3'd3;
  localparam logic [2:0] C_JAL    = 3'd4;
  localparam logic [2:0] C_JALR   = 3'd5;
  localparam logic [2:0] C_FENCE  = 3'd6;
  localparam logic [2:0] C_SYSTEM = 3'd7;

  localparam logic [1:0] F_NONE    = 2'b00;
  localparam logic [1:0] F_ILLEGAL = 2'b01;
  localparam logic [1:0] F_BUS     = 2'b10;

  localparam logic [1:0] PC_PLUS4 = 2'b00;
  localparam logic [1:0] PC_REL   = 2'b01;
  localparam logic [1:0] PC_JALR  = 2'b10;

  localparam logic [1:0] WB_ALU = 2'b00;
  localparam logic [1:0] WB_MEM = 2'b01;
  localparam logic [1:0] WB_PC4 = 2'b10;

  localparam logic [7:0] WAIT_LIMIT = 8'(MEM_TIMEOUT);

  logic [2:0]       state_q, state_d;
  logic [2:0]       class_q, class_d;
  logic [1:0]       fault_q, fault_d;
  logic [7:0]       wait_q;
  logic [CNT_W-1:0] instret_q;
  logic             retire;
  logic             req_c, we_c, instr_c;
  logic [2:0]       dec_class;
  logic             dec_illegal;
  logic             wait_expired;
  logic             waiting;

  // Instruction classification of the latched opcode/funct3.
  always_comb begin
    dec_class   = C_ALU;
    dec_illegal = 1'b0;
    case (opcode)
      7'b0110011, 7'b0010011, 7'b0110111, 7'b0010111: dec_class = C_ALU;
      7'b0000011: begin
        dec_class   = C_LOAD;
        dec_illegal = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
      end
      7'b0100011: begin
        dec_class   = C_STORE;
        dec_illegal = (funct3 > 3'b010);
      end
      7'b1100011: begin
        dec_class   = C_BRANCH;
        dec_illegal = (funct3 == 3'b010) || (funct3 == 3'b011);
      end
      7'b1101111: dec_class = C_JAL;
      7'b1100111: dec_class = C_JALR;
      7'b0001111: dec_class = C_FENCE;
      7'b1110011: dec_class = C_SYSTEM;
      default:    dec_illegal = 1'b1;
    endcase
  end

  // A wait cycle is any FETCH/MEM cycle without an acknowledge. The limit is
  // checked against the count of wait cycles already spent, so the fault fires
  // on request cycle MEM_TIMEOUT+1; an acknowledge in that cycle still wins.
  assign waiting      = ((state_q == S_FETCH) || (state_q == S_MEM)) && !mem.mem_ready;
  assign wait_expired = (wait_q == WAIT_LIMIT);

  always_comb begin
    state_d  = state_q;
    class_d  = class_q;
    fault_d  = fault_q;
    retire   = 1'b0;
    req_c    = 1'b0;
    we_c     = 1'b0;
    instr_c  = 1'b0;
    ir_en    = 1'b0;
    pc_en    = 1'b0;
    pc_sel   = PC_PLUS4;
    reg_w_en = 1'b0;
    wb_sel   = WB_ALU;
    case (state_q)
      S_FETCH: begin
        req_c   = 1'b1;
        instr_c = 1'b1;
        if (mem.mem_ready) begin
          ir_en   = 1'b1;
          state_d = S_DECODE;
        end else if (wait_expired) begin
          state_d = S_HALT;
          fault_d = F_BUS;
        end
      end
      S_DECODE: begin
        class_d = dec_class;
        if (dec_illegal) begin
          state_d = S_HALT;
          fault_d = F_ILLEGAL;
        end else if (dec_class == C_SYSTEM) begin
          state_d = S_HALT;
          fault_d = F_NONE;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        case (class_q)
          C_ALU, C_JAL, C_JALR: state_d = S_WB;
          C_LOAD, C_STORE:      state_d = S_MEM;
          C_BRANCH: begin
            pc_en   = 1'b1;
            pc_sel  = branch_taken ? PC_REL : PC_PLUS4;
            retire  = 1'b1;
            state_d = S_FETCH;
          end
          C_FENCE: begin
            pc_en   = 1'b1;
            retire  = 1'b1;
            state_d = S_FETCH;
          end
          // SYSTEM never reaches EXEC; treat a corrupted class as illegal.
          default: begin
            state_d = S_HALT;
            fault_d = F_ILLEGAL;
          end
        endcase
      end
      S_MEM: begin
        req_c = 1'b1;
        we_c  = (class_q == C_STORE);
        if (mem.mem_ready) begin
          if (class_q == C_STORE) begin
            pc_en   = 1'b1;
            retire  = 1'b1;
            state_d = S_FETCH;
          end else begin
            state_d = S_WB;
          end
        end else if (wait_expired) begin
          state_d = S_HALT;
          fault_d = F_BUS;
        end
      end
      S_WB: begin
        reg_w_en = 1'b1;
        pc_en    = 1'b1;
        if (class_q == C_LOAD) begin
          wb_sel = WB_MEM;
        end else if ((class_q == C_JAL) || (class_q == C_JALR)) begin
          wb_sel = WB_PC4;
        end
        if (class_q == C_JAL) begin
          pc_sel = PC_REL;
        end else if (class_q == C_JALR) begin
          pc_sel = PC_JALR;
        end
        retire  = 1'b1;
        state_d = S_FETCH;
      end
      S_HALT: begin
        state_d = S_HALT;
      end
      // Unused encodings 6 and 7.
      default: begin
        state_d = S_HALT;
        fault_d = F_ILLEGAL;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_FETCH;
      class_q   <= C_ALU;
      fault_q   <= F_NONE;
      wait_q    <= 8'd0;
      instret_q <= '0;
    end else begin
      state_q <= state_d;
      class_q <= class_d;
      fault_q <= fault_d;
      if (state_d != state_q) begin
        wait_q <= 8'd0;
      end else if (waiting) begin
        wait_q <= wait_q + 8'd1;
      end
      if (retire) begin
        instret_q <= instret_q + CNT_W'(1);
      end
    end
  end

  // Gating with reset_n drops an in-flight request the moment reset asserts.
  assign mem.mem_req   = req_c & reset_n;
  assign mem.mem_we    = we_c & reset_n;
  assign mem.mem_instr = instr_c;

  assign halt    = (state_q == S_HALT);
  assign fault   = fault_q;
  assign state   = state_q;
  assign instret = instret_q;

endmodule

// File: doc/core_sequencer.md
# core_sequencer

Multi-cycle control FSM for the RV32I core. It sequences instruction fetch, decode, execute, memory access and write-back over a single shared memory port, using a ready handshake with a bounded wait. It drives the enables and selects of the PC register, instruction register, register file and data memory. It sits between the decoder outputs (opcode/funct3 of the latched instruction) and the datapath, replacing free-running `pc = pc + 4` sequencing.

## Interface
- MEM_TIMEOUT, 15: maximum wait cycles for `mem_ready` before a bus fault (1..255).
- CNT_W, 32: width of the retired-instruction counter.

- clock  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- opcode  in  7  opcode of the latched instruction; valid from DECODE onward.
- funct3  in  3  funct3 of the latched instruction.
- branch_taken  in  1  branch compare result from the ALU; valid in EXEC.
- mem_ready  in  1  memory acknowledge; ignored unless `mem_req`=1.
- mem_req  out  1  memory access request.
- mem_we  out  1  store strobe; only ever high together with `mem_req`.
- mem_instr  out  1  address mux: 1 = pc (fetch), 0 = load/store address.
- ir_en  out  1  instruction register load.
- pc_en  out  1  pc register update.
- pc_sel  out  2  next pc: 00 = pc+4, 01 = pc+imm (branch/JAL), 10 = (rs1+imm)&~1 (JALR).
- reg_w_en  out  1  register file write enable.
- wb_sel  out  2  write-back source: 00 = ALU, 01 = memory, 10 = pc+4.
- halt  out  1  sticky; core stopped.
- fault  out  2  00 = none/ECALL-EBREAK, 01 = illegal instruction, 10 = bus timeout.
- state  out  3  current state, for debug.
- instret  out  CNT_W  count of retired instructions.

## Operation
- State encoding: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=5. Values 6 and 7 go to HALT with fault=01.
- All control outputs are combinational functions of state, the class register and inputs. Outputs default to 0 outside the cases listed below.
- **FETCH**
  - Drives `mem_req`=1, `mem_instr`=1.
  - On `mem_ready`: `ir_en`=1, then DECODE.
- **DECODE**
  - Classifies `opcode`/`funct3` into the class register: ALU (0110011, 0010011, 0110111, 0010111), LOAD (0000011), STORE (0100011), BRANCH (1100011), JAL (1101111), JALR (1100111), FENCE (0001111), SYSTEM (1110011).
  - Illegal cases go to HALT with fault=01:
    - any other opcode;
    - LOAD with funct3 ∈ {011, 110, 111};
    - STORE with funct3 > 010;
    - BRANCH with funct3 ∈ {010, 011}.
  - SYSTEM goes to HALT with fault=00.
  - Otherwise goes to EXEC.
- **EXEC**
  - ALU, JAL, JALR: go to WB.
  - LOAD, STORE: go to MEM.
  - BRANCH: `pc_en`=1, `pc_sel` = `branch_taken` ? 01 : 00; retire; go to FETCH.
  - FENCE: `pc_en`=1, `pc_sel`=00; retire; go to FETCH.
- **MEM**
  - Drives `mem_req`=1, `mem_instr`=0, `mem_we` = (class==STORE).
  - On `mem_ready`, STORE: `pc_en`=1, `pc_sel`=00; retire; go to FETCH.
  - On `mem_ready`, LOAD: go to WB.
- **WB**
  - `reg_w_en`=1, `pc_en`=1.
  - `wb_sel`: 01 for LOAD, 10 for JAL/JALR, else 00.
  - `pc_sel`: 01 for JAL, 10 for JALR, else 00.
  - Retire; go to FETCH.
- **HALT**
  - All enables and requests are 0; `halt`=1; `fault` is held.
  - Exit only via reset.
- **Retire**: `instret` increments by 1 on the edge that leaves the retiring state. It wraps from 2^CNT_W−1 to 0.
- **Wait counter**
  - Counts cycles in FETCH/MEM with `mem_ready`=0; cleared on any state change.
  - If `mem_ready`=0 while the counter equals MEM_TIMEOUT, go to HALT with fault=10.
  - `mem_ready` arriving in that same cycle wins: normal completion, no fault.

## Timing
- Reset (async assert, deassert synchronous to `clock`): state=FETCH, class=ALU, `instret`=0, wait counter=0, `halt`=0, `fault`=00.
  - `mem_req`=1 combinationally from the first cycle after reset.
- With `mem_ready` returned in the same cycle as the request, cycles per instruction are:
  - ALU/JAL/JALR: 4 (F, D, E, WB);
  - LOAD: 5;
  - STORE: 4;
  - BRANCH/FENCE: 3.
- Each wait cycle on `mem_ready` adds 1 cycle in FETCH or MEM.
- `mem_req`, `mem_we` and `mem_instr` stay stable until the handshake completes or the timeout fires. A request is never withdrawn early, except by reset.
- `ir_en`, `pc_en` and `reg_w_en` are single-cycle pulses, each at most once per instruction.
- Reset asserted mid-access drops `mem_req` immediately. No partial write is tracked.

## Test plan
- **Reset, then ADDI (0010011), ready always 1**
  - States go 0,1,2,4,0.
  - `ir_en` pulses in cycle 0; `reg_w_en` and `pc_en` (`pc_sel`=00) in cycle 3.
  - `instret`=1 after cycle 3.
- **LW with `mem_ready` delayed 3 cycles in MEM**
  - `mem_we`=0 and `mem_req` held for 4 cycles.
  - WB with `wb_sel`=01; 8 cycles total.
- **BEQ, `branch_taken`=1, then `branch_taken`=0**
  - `pc_sel`=01, then 00, each on the EXEC cycle.
  - No `reg_w_en`; `instret`=2.
- **JALR**
  - WB asserts `wb_sel`=10, `pc_sel`=10, `reg_w_en`=1.
- **Illegal opcode 0000000**
  - HALT with fault=01; `halt`=1 forever.
  - No `pc_en`/`reg_w_en`; `instret` unchanged.
  - `mem_ready` toggling is ignored.
- **Bus timeout and boundaries**
  - `mem_ready`=0 in FETCH: HALT with fault=10 after exactly MEM_TIMEOUT+1 request cycles (16 at default).
  - Repeat with `mem_ready`=1 on the 16th cycle: DECODE, no fault.
  - Preload `instret` to all-ones: it wraps to 0.
